// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared encodings and default sizes for the data-memory arbiter
package dmem_arb_pkg;
   localparam int ADDR_W_DEF       = 15;
   localparam int DATA_W_DEF       = 16;
   localparam int MAX_BURST_DEF    = 8;
   localparam int STARVE_LIMIT_DEF = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_DMA} state_t;
   typedef enum logic {OWN_CPU, OWN_DMA} owner_t;
endpackage

// File: rtl/dmem_arbiter_starve.sv
// arb_starve_ctr: saturating count of ungranted DMA cycles with a limit-hit flag
module arb_starve_ctr
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_hit
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] r_cnt;
   assign o_hit = (r_cnt == CW'(STARVE_LIMIT));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_inc && !o_hit) r_cnt <= r_cnt + CW'(1);
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-side memory port between the CPU memory stage and a DMA master
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int MAX_BURST    = MAX_BURST_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_last,
   output logic              dma_gnt,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   state_t            r_state, w_next;
   owner_t            r_rd_own;
   logic              r_rd_vld;
   logic [BW-1:0]     r_beat;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_cpu_rdata, r_dma_rdata;
   logic              w_cpu_gnt, w_dma_gnt, w_starve_hit, w_burst_end;

   arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (dma_req && !w_dma_gnt),
      .i_clr (w_dma_gnt),
      .o_hit (w_starve_hit)
   );

   // grants are forced low while reset is held so every output sits at its reset value
   always_comb begin
      w_cpu_gnt   = rst_n && cpu_req && !w_starve_hit && !(r_state == ST_DMA && dma_req);
      w_dma_gnt   = rst_n && dma_req && !w_cpu_gnt;
      w_burst_end = dma_last || (r_beat == BW'(MAX_BURST - 1));
      w_next      = w_dma_gnt ? (w_burst_end ? ST_IDLE : ST_DMA) : (w_cpu_gnt ? ST_CPU : ST_IDLE);
   end

   assign dma_gnt    = w_dma_gnt;
   assign cpu_stall  = cpu_req && !w_cpu_gnt && rst_n;
   assign mem_we     = (w_cpu_gnt && cpu_we) || (w_dma_gnt && dma_we);
   assign mem_addr   = w_cpu_gnt ? cpu_addr : (w_dma_gnt ? dma_addr : r_addr);
   assign mem_wdata  = w_cpu_gnt ? cpu_wdata : dma_wdata;
   assign cpu_rvalid = r_rd_vld && (r_rd_own == OWN_CPU);
   assign dma_rvalid = r_rd_vld && (r_rd_own == OWN_DMA);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : r_cpu_rdata;
   assign dma_rdata  = dma_rvalid ? mem_rdata : r_dma_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_beat      <= '0;
         r_addr      <= '0;
         r_rd_vld    <= 1'b0;
         r_rd_own    <= OWN_CPU;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         r_state     <= w_next;
         r_beat      <= (w_next == ST_DMA) ? r_beat + BW'(1) : '0;
         r_addr      <= mem_addr;
         r_rd_vld    <= (w_cpu_gnt && !cpu_we) || (w_dma_gnt && !dma_we);
         r_rd_own    <= w_dma_gnt ? OWN_DMA : OWN_CPU;
         r_cpu_rdata <= cpu_rdata;
         r_dma_rdata <= dma_rdata;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenario tests for dmem_arbiter against a synchronous memory model
module tb_dmem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, cpu_stall, cpu_rvalid;
   logic [14:0] cpu_addr;
   logic [15:0] cpu_wdata, cpu_rdata;
   logic        dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
   logic [14:0] dma_addr;
   logic [15:0] dma_wdata, dma_rdata;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata, mem_rdata;
   logic [15:0] tb_mem [0:255];
   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [15:0] pl_data;
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (pl_en) tb_mem[pl_addr] <= pl_data;
      else if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
      mem_rdata <= tb_mem[mem_addr[7:0]];
   end

   task automatic test_reset;
      rst_n = 1'b0; pl_en = 1'b1; pl_addr = 8'h10; pl_data = 16'hBEEF;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h5; cpu_wdata = 16'h1;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h6; dma_wdata = 16'h2; dma_last = 1'b0;
      #1;
      n_chk++; if (dma_gnt !== 1'b0) begin n_err++; $display("FAIL rst_dma_gnt got %b want 0", dma_gnt); end
      n_chk++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_cpu_stall got %b want 0", cpu_stall); end
      n_chk++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
      n_chk++; if (mem_addr !== 15'h0) begin n_err++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
      n_chk++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid got %b want 00", {cpu_rvalid, dma_rvalid}); end
      n_chk++; if ({cpu_rdata, dma_rdata} !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", {cpu_rdata, dma_rdata}); end
      @(negedge clk);
      pl_en = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_cpu_load;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h10;
      #1;
      n_chk++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL load_stall got %b want 0", cpu_stall); end
      n_chk++; if (mem_addr !== 15'h10 || mem_we !== 1'b0) begin n_err++; $display("FAIL load_mem got addr %h we %b want 0010 0", mem_addr, mem_we); end
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      n_chk++; if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0) begin n_err++; $display("FAIL load_rvalid got cpu %b dma %b want 1 0", cpu_rvalid, dma_rvalid); end
      n_chk++; if (cpu_rdata !== 16'hBEEF) begin n_err++; $display("FAIL load_rdata got %h want beef", cpu_rdata); end
      @(negedge clk);
      #1;
      n_chk++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF) begin n_err++; $display("FAIL load_hold got rvalid %b data %h want 0 beef", cpu_rvalid, cpu_rdata); end
   endtask

   task automatic test_starve;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h11;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h50; dma_wdata = 16'h5555; dma_last = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         n_chk++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL starve_cpu_win cycle %0d got gnt %b stall %b want 0 0", i, dma_gnt, cpu_stall); end
         @(negedge clk);
      end
      #1;
      n_chk++; if (dma_gnt !== 1'b1 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL starve_dma_win got gnt %b stall %b want 1 1", dma_gnt, cpu_stall); end
      n_chk++; if (mem_addr !== 15'h50 || mem_we !== 1'b1) begin n_err++; $display("FAIL starve_mem got addr %h we %b want 0050 1", mem_addr, mem_we); end
      @(negedge clk);
      dma_req = 1'b0;
      #1;
      n_chk++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL starve_cpu_after got stall %b want 0", cpu_stall); end
      cpu_req = 1'b0;
   endtask

   task automatic test_max_burst;
      logic [14:0] ea;
      int b;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         b = (c < 8) ? c : c - 1;
         dma_req = (c < 13); dma_we = 1'b1; dma_last = 1'b0;
         dma_addr = 15'(15'h60 + b); dma_wdata = 16'(16'hA000 + b);
         cpu_req = (c >= 2 && c <= 8); cpu_we = 1'b1; cpu_addr = 15'h40; cpu_wdata = 16'h4444;
         ea = (c == 8) ? 15'h40 : (c == 13) ? 15'h6B : 15'(15'h60 + b);
         #1;
         n_chk++; if (dma_gnt !== (c < 13 && c != 8)) begin n_err++; $display("FAIL burst_gnt cycle %0d got %b want %b", c, dma_gnt, (c < 13 && c != 8)); end
         n_chk++; if (cpu_stall !== (c >= 2 && c <= 7)) begin n_err++; $display("FAIL burst_stall cycle %0d got %b want %b", c, cpu_stall, (c >= 2 && c <= 7)); end
         n_chk++; if (mem_addr !== ea) begin n_err++; $display("FAIL burst_addr cycle %0d got %h want %h", c, mem_addr, ea); end
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      n_chk++; if (tb_mem[8'h67] !== 16'hA007 || tb_mem[8'h6B] !== 16'hA00B) begin n_err++; $display("FAIL burst_mem got %h %h want a007 a00b", tb_mem[8'h67], tb_mem[8'h6B]); end
      n_chk++; if (tb_mem[8'h40] !== 16'h4444) begin n_err++; $display("FAIL burst_cpu_store got %h want 4444", tb_mem[8'h40]); end
   endtask

   task automatic test_last;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'(15'h70 + c); dma_wdata = 16'(16'hB000 + c); dma_last = (c == 2);
         #1;
         n_chk++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL last_beat %0d got gnt %b want 1", c, dma_gnt); end
      end
      @(negedge clk);
      dma_addr = 15'h78; dma_wdata = 16'hB008; dma_last = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h20; cpu_wdata = 16'h1234;
      #1;
      n_chk++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin n_err++; $display("FAIL last_idle got stall %b gnt %b want 0 0", cpu_stall, dma_gnt); end
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      n_chk++; if (dma_gnt !== 1'b1 || mem_addr !== 15'h78) begin n_err++; $display("FAIL last_dma_resume got gnt %b addr %h want 1 0078", dma_gnt, mem_addr); end
      @(negedge clk);
      dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h20;
      #1;
      n_chk++; if (cpu_stall !== 1'b0 || mem_addr !== 15'h20) begin n_err++; $display("FAIL last_readback_gnt got stall %b addr %h want 0 0020", cpu_stall, mem_addr); end
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      n_chk++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 16'h1234) begin n_err++; $display("FAIL last_readback got rvalid %b data %h want 1 1234", cpu_rvalid, cpu_rdata); end
   endtask

   task automatic test_interleave;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h10;
      #1;
      n_chk++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL inter_cpu_gnt got stall %b want 0", cpu_stall); end
      @(negedge clk);
      cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h70; dma_last = 1'b1;
      #1;
      n_chk++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL inter_dma_gnt got %b want 1", dma_gnt); end
      n_chk++; if (cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF) begin n_err++; $display("FAIL inter_cpu_resp got cv %b dv %b data %h want 1 0 beef", cpu_rvalid, dma_rvalid, cpu_rdata); end
      @(negedge clk);
      dma_req = 1'b0;
      #1;
      n_chk++; if (dma_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || dma_rdata !== 16'hB000) begin n_err++; $display("FAIL inter_dma_resp got dv %b cv %b data %h want 1 0 b000", dma_rvalid, cpu_rvalid, dma_rdata); end
      n_chk++; if (cpu_rdata !== 16'hBEEF) begin n_err++; $display("FAIL inter_cpu_hold got %h want beef", cpu_rdata); end
      @(negedge clk);
      #1;
      n_chk++; if ({cpu_rvalid, dma_rvalid} !== 2'b00 || dma_rdata !== 16'hB000) begin n_err++; $display("FAIL inter_quiet got v %b data %h want 00 b000", {cpu_rvalid, dma_rvalid}, dma_rdata); end
   endtask

   task automatic test_reset_mid;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'(15'h60 + c); dma_last = 1'b0;
         cpu_req = (c == 2); cpu_we = 1'b0; cpu_addr = 15'h10;
         #1;
         n_chk++; if (dma_gnt !== 1'b1) begin n_err++; $display("FAIL rmid_beat %0d got gnt %b want 1", c, dma_gnt); end
      end
      n_chk++; if (dma_rvalid !== 1'b1 || dma_rdata !== 16'hA001 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL rmid_resp got v %b data %h stall %b want 1 a001 1", dma_rvalid, dma_rdata, cpu_stall); end
      rst_n = 1'b0;
      #1;
      n_chk++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_we !== 1'b0) begin n_err++; $display("FAIL rmid_ctl got gnt %b stall %b we %b want 0 0 0", dma_gnt, cpu_stall, mem_we); end
      n_chk++; if ({cpu_rvalid, dma_rvalid} !== 2'b00 || {cpu_rdata, dma_rdata} !== 32'h0) begin n_err++; $display("FAIL rmid_rd got v %b data %h want 00 0", {cpu_rvalid, dma_rvalid}, {cpu_rdata, dma_rdata}); end
      n_chk++; if (mem_addr !== 15'h0) begin n_err++; $display("FAIL rmid_addr got %h want 0", mem_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_chk++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin n_err++; $display("FAIL rmid_first_gnt got stall %b gnt %b want 0 0", cpu_stall, dma_gnt); end
      n_chk++; if (dma_rvalid !== 1'b0) begin n_err++; $display("FAIL rmid_no_rvalid got %b want 0", dma_rvalid); end
      @(negedge clk);
      cpu_req = 1'b0; dma_req = 1'b0;
      #1;
      n_chk++; if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b1 || cpu_rdata !== 16'hBEEF) begin n_err++; $display("FAIL rmid_post got dv %b cv %b data %h want 0 1 beef", dma_rvalid, cpu_rvalid, cpu_rdata); end
   endtask

   initial begin
      test_reset();
      test_cpu_load();
      test_starve();
      test_max_burst();
      test_last();
      test_interleave();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
